// File: rtl/mem_wb_stage.sv
// MEM + MEM/WB stage of the RV32I core: runs loads and stores over a req/rvalid data-memory
// handshake, stalls upstream while an access is outstanding, and registers the writeback triple.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_m_i,
  input  logic [31:0] alu_m_i,
  input  logic [31:0] rs2_m_i,
  input  logic [31:0] pc4_m_i,
  input  logic [31:0] inst_m_i,
  input  logic        MemRW_m_i,
  input  logic [1:0]  WBSel_m_i,
  input  logic        RegWEn_m_i,
  input  logic [4:0]  rsW_m_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] data_wb_o,
  output logic [4:0]  rsW_o,
  output logic        RegWEn_o,
  output logic        err_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Access size comes from funct3[1:0] for both loads and stores: 00 byte, 01 half, else word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  res = {24'h000000, shifted[7:0]};
      3'b001:  res = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  res = {16'h0000, shifted[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    ld_rsw_q, ld_rsw_d;
  logic          ld_wen_q, ld_wen_d;
  logic [31:0]   data_wb_q, data_wb_d;
  logic [4:0]    rsw_q, rsw_d;
  logic          wen_q, wen_d;
  logic          err_q, err_d;
  logic          stall_s;

  logic [2:0]    f3_s;
  logic [1:0]    off_s;
  logic          mem_op_s;
  logic          mis_s;
  logic          wen_s;

  assign f3_s     = inst_m_i[14:12];
  assign off_s    = alu_m_i[1:0];
  assign mem_op_s = valid_m_i & (MemRW_m_i | (WBSel_m_i == 2'b00));
  assign mis_s    = is_misaligned(f3_s, off_s);
  assign wen_s    = RegWEn_m_i & (rsW_m_i != 5'd0);

  // Next-state, access latching and writeback selection; WB regs default to a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    off_d     = off_q;
    ld_rsw_d  = ld_rsw_q;
    ld_wen_d  = ld_wen_q;
    data_wb_d = 32'h0000_0000;
    rsw_d     = 5'd0;
    wen_d     = 1'b0;
    err_d     = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          if (mis_s) begin
            err_d = 1'b1;
          end else begin
            state_d  = WAIT;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = MemRW_m_i;
            addr_d   = {alu_m_i[31:2], 2'b00};
            wdata_d  = store_wdata(f3_s, rs2_m_i);
            be_d     = store_be(f3_s, off_s);
            f3_d     = f3_s;
            off_d    = off_s;
            ld_rsw_d = rsW_m_i;
            ld_wen_d = wen_s & ~MemRW_m_i;
            stall_s  = 1'b1;
          end
        end else if (valid_m_i) begin
          data_wb_d = (WBSel_m_i == 2'b10) ? pc4_m_i : alu_m_i;
          rsw_d     = rsW_m_i;
          wen_d     = wen_s;
        end else begin
          data_wb_d = 32'h0000_0000;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            data_wb_d = load_align(f3_q, off_q, dmem_rdata_i);
            rsw_d     = ld_rsw_q;
            wen_d     = ld_wen_q;
          end else begin
            wen_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: the op retires as a bubble so upstream can move on.
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, latched access and writeback registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      be_q      <= 4'b0000;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      ld_rsw_q  <= 5'd0;
      ld_wen_q  <= 1'b0;
      data_wb_q <= 32'h0000_0000;
      rsw_q     <= 5'd0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      ld_rsw_q  <= ld_rsw_d;
      ld_wen_q  <= ld_wen_d;
      data_wb_q <= data_wb_d;
      rsw_q     <= rsw_d;
      wen_q     <= wen_d;
      err_q     <= err_d;
    end
  end

  // Stall is combinational on the incoming op, so keep it quiet while reset is held.
  assign stall_o      = stall_s & rst_ni;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q & req_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign data_wb_o    = data_wb_q;
  assign rsW_o        = rsw_q;
  assign RegWEn_o     = wen_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a behavioural model of load/store lane rules.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_m_i = 1'b0;
  logic [31:0] alu_m_i = 32'h0;
  logic [31:0] rs2_m_i = 32'h0;
  logic [31:0] pc4_m_i = 32'h0;
  logic [31:0] inst_m_i = 32'h0;
  logic        MemRW_m_i = 1'b0;
  logic [1:0]  WBSel_m_i = 2'b01;
  logic        RegWEn_m_i = 1'b0;
  logic [4:0]  rsW_m_i = 5'd0;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic [31:0] data_wb_o;
  logic [4:0]  rsW_o;
  logic        RegWEn_o, err_o;

  int vec = 0;
  int errs = 0;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_m_i(valid_m_i), .alu_m_i(alu_m_i),
    .rs2_m_i(rs2_m_i), .pc4_m_i(pc4_m_i), .inst_m_i(inst_m_i), .MemRW_m_i(MemRW_m_i),
    .WBSel_m_i(WBSel_m_i), .RegWEn_m_i(RegWEn_m_i), .rsW_m_i(rsW_m_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .data_wb_o(data_wb_o), .rsW_o(rsW_o),
    .RegWEn_o(RegWEn_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int sz;
    logic [63:0] v, mask;
    sz = acc_size(f3);
    if (sz == 4) return rdata;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = ({32'h0, rdata} >> (8 * int'(addr % 4))) & mask;
    if (f3[2] == 1'b0 && v >= (64'd1 << (8 * sz - 1))) v = v + (~mask);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] f3);
    int sz;
    logic [3:0] be;
    sz = acc_size(f3);
    be = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= int'(addr % 4) && b < int'(addr % 4) + sz) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    int sz;
    logic [31:0] wd;
    sz = acc_size(f3);
    for (int b = 0; b < 4; b++) wd[8*b +: 8] = rs2[8*(b % sz) +: 8];
    return wd;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rw, input logic [1:0] wbs, input logic wen,
                        input logic [4:0] rsw, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] pc4, input logic [2:0] f3);
    logic [31:0] inst;
    inst = $urandom;
    inst[14:12] = f3;
    valid_m_i = v; MemRW_m_i = rw; WBSel_m_i = wbs; RegWEn_m_i = wen; rsW_m_i = rsw;
    alu_m_i = alu; rs2_m_i = rs2; pc4_m_i = pc4; inst_m_i = inst;
  endtask

  task automatic go_idle();
    valid_m_i = 1'b0; MemRW_m_i = 1'b0; WBSel_m_i = 2'b01; RegWEn_m_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    set_op(1'b1, 1'b0, 2'b00, 1'b1, 5'd4, 32'h0000_0100, 32'h0, 32'h0, 3'b010);
    tick(); tick();
    vec++; if (stall_o !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    vec++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, data_wb_o, rsW_o, RegWEn_o, err_o} !== 109'd0) begin
      errs++; $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b wb=%h rd=%0d wen=%b err=%b want all 0",
        dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, data_wb_o, rsW_o, RegWEn_o, err_o);
    end
    go_idle();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_alu(input int n);
    logic [1:0] wbs; logic [4:0] rsw; logic wen; logic [31:0] alu, pc4, exp_d; logic exp_w;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        wbs = 2'b01; rsw = 5'd3; wen = 1'b1; alu = 32'h5; pc4 = 32'h44;
      end else begin
        wbs = 2'($urandom_range(1, 3)); rsw = 5'($urandom_range(0, 31));
        wen = 1'($urandom_range(0, 1)); alu = $urandom; pc4 = $urandom;
      end
      set_op(1'b1, 1'b0, wbs, wen, rsw, alu, $urandom, pc4, 3'($urandom_range(0, 7)));
      #1;
      vec++; if (stall_o !== 1'b0) begin errs++; $display("FAIL alu_stall: got %b want 0", stall_o); end
      tick();
      exp_d = (wbs == 2'b10) ? pc4 : alu;
      exp_w = wen && (rsw != 5'd0);
      vec++; if (RegWEn_o !== exp_w) begin errs++; $display("FAIL alu_wen: got %b want %b", RegWEn_o, exp_w); end
      if (exp_w) begin
        vec++; if (data_wb_o !== exp_d) begin errs++; $display("FAIL alu_data: got %h want %h", data_wb_o, exp_d); end
        vec++; if (rsW_o !== rsw) begin errs++; $display("FAIL alu_rd: got %0d want %0d", rsW_o, rsw); end
      end
      vec++; if ({dmem_req_o, err_o} !== 2'b00) begin errs++; $display("FAIL alu_req_err: got %b want 00", {dmem_req_o, err_o}); end
    end
    go_idle();
    tick();
  endtask

  // Loads follow each other without idle cycles in between.
  task automatic test_loads(input int n);
    logic [2:0] f3; logic [31:0] addr, rdata, exp_d; logic [4:0] rsw; logic wen, exp_w; int d, sz;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        f3 = 3'b000; addr = 32'h0000_0103; d = 3; rdata = 32'h80FF_FF11; rsw = 5'd5; wen = 1'b1;
      end else begin
        f3 = 3'($urandom_range(0, 7)); sz = acc_size(f3);
        addr = ($urandom & 32'hFFFF_FFFC) + 32'(sz * $urandom_range(0, 4 / sz - 1));
        d = $urandom_range(1, 5); rdata = $urandom;
        rsw = (i == 1) ? 5'd0 : 5'($urandom_range(0, 31));
        wen = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      set_op(1'b1, 1'b0, 2'b00, wen, rsw, addr, $urandom, $urandom, f3);
      #1;
      vec++; if ({stall_o, dmem_req_o} !== 2'b10) begin errs++; $display("FAIL ld_issue: stall,req got %b want 10", {stall_o, dmem_req_o}); end
      tick();
      for (int k = 1; k <= d; k++) begin
        vec++; if ({dmem_req_o, dmem_we_o} !== 2'b10) begin errs++; $display("FAIL ld_req: req,we got %b want 10 (cycle %0d)", {dmem_req_o, dmem_we_o}, k); end
        vec++; if (dmem_addr_o !== (addr & 32'hFFFF_FFFC)) begin errs++; $display("FAIL ld_addr: got %h want %h", dmem_addr_o, addr & 32'hFFFF_FFFC); end
        vec++; if (RegWEn_o !== 1'b0) begin errs++; $display("FAIL ld_wait_wen: got %b want 0", RegWEn_o); end
        dmem_rvalid_i = (k == d);
        dmem_rdata_i = (k == d) ? rdata : $urandom;
        #1;
        vec++; if (stall_o !== (k != d)) begin errs++; $display("FAIL ld_stall: got %b want %b (cycle %0d)", stall_o, k != d, k); end
        tick();
      end
      dmem_rvalid_i = 1'b0;
      exp_d = model_load(rdata, addr, f3);
      exp_w = wen && (rsw != 5'd0);
      vec++; if ({dmem_req_o, err_o} !== 2'b00) begin errs++; $display("FAIL ld_done: req,err got %b want 00", {dmem_req_o, err_o}); end
      vec++; if (RegWEn_o !== exp_w) begin errs++; $display("FAIL ld_wen: got %b want %b", RegWEn_o, exp_w); end
      if (exp_w) begin
        vec++; if (data_wb_o !== exp_d) begin errs++; $display("FAIL ld_data: f3=%0d addr=%h got %h want %h", f3, addr, data_wb_o, exp_d); end
        vec++; if (rsW_o !== rsw) begin errs++; $display("FAIL ld_rd: got %0d want %0d", rsW_o, rsw); end
      end
    end
    go_idle();
    tick();
  endtask

  task automatic test_stores(input int n);
    logic [2:0] f3; logic [31:0] addr, rs2; int d, sz;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        f3 = 3'b001; addr = 32'h0000_0202; rs2 = 32'h0000_ABCD; d = 2;
      end else begin
        f3 = 3'($urandom_range(0, 2)); sz = acc_size(f3);
        addr = ($urandom & 32'hFFFF_FFFC) + 32'(sz * $urandom_range(0, 4 / sz - 1));
        rs2 = $urandom; d = $urandom_range(1, 4);
      end
      set_op(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b1, 5'($urandom_range(1, 31)), addr, rs2, $urandom, f3);
      #1;
      vec++; if (stall_o !== 1'b1) begin errs++; $display("FAIL st_stall: got %b want 1", stall_o); end
      tick();
      for (int k = 1; k <= d; k++) begin
        vec++; if ({dmem_req_o, dmem_we_o} !== 2'b11) begin errs++; $display("FAIL st_req: req,we got %b want 11", {dmem_req_o, dmem_we_o}); end
        vec++; if (dmem_be_o !== model_be(addr, f3)) begin errs++; $display("FAIL st_be: got %b want %b", dmem_be_o, model_be(addr, f3)); end
        vec++; if (dmem_wdata_o !== model_wdata(rs2, f3)) begin errs++; $display("FAIL st_wdata: got %h want %h", dmem_wdata_o, model_wdata(rs2, f3)); end
        vec++; if (dmem_addr_o !== (addr & 32'hFFFF_FFFC)) begin errs++; $display("FAIL st_addr: got %h want %h", dmem_addr_o, addr & 32'hFFFF_FFFC); end
        dmem_rvalid_i = (k == d);
        #1;
        vec++; if (stall_o !== (k != d)) begin errs++; $display("FAIL st_wait_stall: got %b want %b", stall_o, k != d); end
        tick();
      end
      dmem_rvalid_i = 1'b0;
      vec++; if ({dmem_req_o, RegWEn_o, err_o} !== 3'b000) begin errs++; $display("FAIL st_done: req,wen,err got %b want 000", {dmem_req_o, RegWEn_o, err_o}); end
    end
    go_idle();
    tick();
  endtask

  task automatic test_misaligned(input int n);
    logic [2:0] f3; logic [31:0] addr; logic rw; int sz;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        f3 = 3'b010; addr = 32'h0000_0001; rw = 1'b0;
      end else begin
        rw = 1'($urandom_range(0, 1));
        do f3 = rw ? 3'($urandom_range(1, 2)) : 3'($urandom_range(0, 7)); while (acc_size(f3) == 1);
        sz = acc_size(f3);
        do addr = $urandom; while ((addr % sz) == 0);
      end
      set_op(1'b1, rw, rw ? 2'b01 : 2'b00, 1'b1, 5'd6, addr, $urandom, $urandom, f3);
      #1;
      vec++; if (stall_o !== 1'b0) begin errs++; $display("FAIL mis_stall: got %b want 0", stall_o); end
      tick();
      go_idle();
      vec++; if ({dmem_req_o, err_o, RegWEn_o} !== 3'b010) begin errs++; $display("FAIL mis_pulse: req,err,wen got %b want 010", {dmem_req_o, err_o, RegWEn_o}); end
      tick();
      vec++; if ({dmem_req_o, err_o} !== 2'b00) begin errs++; $display("FAIL mis_after: req,err got %b want 00", {dmem_req_o, err_o}); end
    end
  endtask

  task automatic test_timeout();
    int stalls, reqs;
    set_op(1'b1, 1'b0, 2'b00, 1'b1, 5'd7, 32'h0000_0400, $urandom, $urandom, 3'b010);
    #1;
    stalls = stall_o ? 1 : 0;
    reqs = 0;
    tick();
    for (int c = 0; c < 40 && dmem_req_o; c++) begin
      reqs++;
      if (stall_o) stalls++;
      tick();
    end
    go_idle();
    vec++; if (stalls !== TIMEOUT) begin errs++; $display("FAIL to_stalls: got %0d want %0d", stalls, TIMEOUT); end
    vec++; if (reqs !== TIMEOUT) begin errs++; $display("FAIL to_reqs: got %0d want %0d", reqs, TIMEOUT); end
    vec++; if ({err_o, RegWEn_o} !== 2'b10) begin errs++; $display("FAIL to_pulse: err,wen got %b want 10", {err_o, RegWEn_o}); end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = $urandom;
    #1;
    vec++; if (stall_o !== 1'b0) begin errs++; $display("FAIL to_late_stall: got %b want 0", stall_o); end
    tick();
    dmem_rvalid_i = 1'b0;
    vec++; if ({dmem_req_o, err_o, RegWEn_o} !== 3'b000) begin errs++; $display("FAIL to_late_rvalid: req,err,wen got %b want 000", {dmem_req_o, err_o, RegWEn_o}); end
  endtask

  task automatic test_reset_in_wait();
    set_op(1'b1, 1'b0, 2'b00, 1'b1, 5'd9, 32'h0000_0800, $urandom, $urandom, 3'b010);
    tick();
    vec++; if (dmem_req_o !== 1'b1) begin errs++; $display("FAIL rw_req: got %b want 1", dmem_req_o); end
    rst_ni = 1'b0;
    tick();
    vec++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, data_wb_o, rsW_o, RegWEn_o, err_o} !== 78'd0) begin
      errs++; $display("FAIL rw_outputs: stall=%b req=%b addr=%h wen=%b err=%b want all 0",
        stall_o, dmem_req_o, dmem_addr_o, RegWEn_o, err_o);
    end
    rst_ni = 1'b1;
    go_idle();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = $urandom;
    tick();
    dmem_rvalid_i = 1'b0;
    vec++; if ({dmem_req_o, RegWEn_o, err_o} !== 3'b000) begin errs++; $display("FAIL rw_ignore: req,wen,err got %b want 000", {dmem_req_o, RegWEn_o, err_o}); end
  endtask

  initial begin
    test_reset();
    test_alu(20);
    test_loads(30);
    test_stores(20);
    test_misaligned(12);
    test_timeout();
    test_reset_in_wait();
    test_loads(5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
